mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Multicycle signed MULT/DIV unit downstream of the ALU B-operand select: takes regA and the selected B operand.
//  Runs radix-2 Booth multiply or restoring divide over WIDTH cycles and writes the HI/LO pair read by MFHI/MFLO.
//  The control FSM pulses a start, then stalls on busy until done.
// PARAMETERS
//  WIDTH  32  operand width; HI/LO are WIDTH each, product is 2*WIDTH
// PORTS
//  clk         in   1      single clock, rising edge
//  reset_n     in   1      asynchronous, active-low reset
//  start_mult  in   1      start signed multiply (sampled only in IDLE)
//  start_div   in   1      start signed divide (sampled only in IDLE)
//  op_a        in   WIDTH  multiplicand / dividend (regA)
//  op_b        in   WIDTH  multiplier / divisor (B operand)
//  hi          out  WIDTH  MULT: product[2W-1:W]; DIV: remainder
//  lo          out  WIDTH  MULT: product[W-1:0];  DIV: quotient
//  busy        out  1      high from the cycle after an accepted start until done
//  done        out  1      one-cycle pulse; hi/lo valid on the same cycle
//  div_zero    out  1      one-cycle pulse alongside done when divisor == 0
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE; hi, lo = 0; busy, done, div_zero = 0; any op in flight is abandoned.
//  - States: IDLE, MULT, DIV, DIV_FIX, FINISH.
//  - IDLE: if start_mult, latch operands -> MULT; elif start_div -> DIV, or -> FINISH with div_zero flagged if op_b==0.
//  - Simultaneous start_mult & start_div: multiply wins; start_div is dropped.
//  - Starts while busy are ignored (no queueing).
//  - Operands are latched at the accepting edge; later op_a/op_b changes have no effect.
//  - MULT: Booth radix-2 over {A(W+1 bit, sign-ext), Q, q-1}; WIDTH iterations; counter WIDTH-1..0, then -> FINISH.
//  - DIV: restoring divide on |op_a|, |op_b| (magnitudes in W+1 bits so -2^(W-1) is exact); WIDTH iterations, then -> DIV_FIX.
//  - DIV_FIX: quotient negated if signs differ; remainder takes the sign of the dividend (truncate toward zero).
//  - FINISH: hi/lo updated, done=1 for exactly this cycle, busy=0; -> IDLE. A start may be accepted the following cycle.
//  - Latency, start-accept edge = cycle 0: MULT done at cycle WIDTH+1; DIV done at WIDTH+2; div-by-zero done at cycle 1.
//  - Div-by-zero: hi, lo keep their previous values; div_zero pulses with done.
//  - Overflow (-2^(W-1) / -1): lo = 0x8000_0000 (wraps), hi = 0; no flag.
//  - hi/lo change only in FINISH (non-zero divisor) or on reset; they hold across IDLE.
//  - busy is low in IDLE and FINISH, high in MULT/DIV/DIV_FIX.
// STRUCTURE
//  - Shared package: state encoding constants (IDLE..FINISH, 3 bits) and WIDTH default.
//  - Sub-module: div_core (restoring divider datapath: remainder/quotient shift regs + subtractor).
//  - Booth datapath and FSM stay in this module.
//  - Iteration counter: $clog2(WIDTH)+1 bits, shared by MULT and DIV.
// TESTING
//  - MULT 7 * -3 -> hi=0xFFFF_FFFF, lo=0xFFFF_FFEB, done at cycle 33, busy high cycles 1-32.
//  - MULT 0x8000_0000 * 0x8000_0000 -> hi=0x4000_0000, lo=0.
//  - MULT 0x7FFF_FFFF * 0x7FFF_FFFF -> hi=0x3FFF_FFFF, lo=0x0000_0001.
//  - DIV -7/2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF, done at cycle 34.
//  - DIV 7/-2 -> lo=-3, hi=+1.
//  - DIV 0x8000_0000 / -1 -> lo=0x8000_0000, hi=0, div_zero=0.
//  - DIV 5/0 with prior hi=0x11, lo=0x22 -> done and div_zero pulse at cycle 1; hi/lo unchanged.
//  - start_div pulsed mid-MULT: ignored, MULT result exact.
//  - start_mult & start_div same cycle: multiply is performed.
//  - reset_n low at cycle 10 of DIV -> hi=lo=0, busy=0 immediately; new MULT 3*4 -> lo=12.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared constants for the multicycle MULT/DIV unit: FSM state encoding and default width.
package mult_div_unit_pkg;
   localparam int DEF_WIDTH = 32;

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] MULT    = 3'd1;
   localparam logic [2:0] DIV     = 3'd2;
   localparam logic [2:0] DIV_FIX = 3'd3;
   localparam logic [2:0] FINISH  = 3'd4;
endpackage

// File: rtl/mult_div_unit_div_core.sv
// Restoring divider datapath on unsigned magnitudes; one quotient bit per step.
module div_core #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH:0]   divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);
   logic [WIDTH:0]   rem;
   logic [WIDTH:0]   dvsr;
   logic [WIDTH-1:0] quo;
   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] diff;

   // Partial remainder stays below the divisor, so one extra bit plus the shifted-in bit suffice.
   assign shifted = {rem, quo[WIDTH-1]};
   assign diff    = shifted - {1'b0, dvsr};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rem  <= '0;
         quo  <= '0;
         dvsr <= '0;
      end else if (load) begin
         rem  <= '0;
         quo  <= dividend;
         dvsr <= divisor;
      end else if (step) begin
         if (!diff[WIDTH+1]) begin
            rem <= diff[WIDTH:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
         end else begin
            rem <= shifted[WIDTH:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
         end
      end
   end

   assign quotient  = quo;
   assign remainder = rem[WIDTH-1:0];
endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT (Booth radix-2) / DIV (restoring) unit writing the HI/LO pair.
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start_mult,
   input  logic             start_div,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);
   localparam int CW = $clog2(WIDTH) + 1;

   logic [2:0]       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   boothA, mcand, boothSum;
   logic [WIDTH-1:0] boothQ;
   logic             qm1;
   logic             negQ, negR, dzFlag;
   logic [WIDTH-1:0] resHi, resLo;
   logic [WIDTH-1:0] aMag, divQuo, divRem;
   logic [WIDTH:0]   bMag;
   logic             divLoad, divStep;

   always_comb begin
      boothSum = boothA;
      case ({boothQ[0], qm1})
         2'b01:   boothSum = boothA + mcand;
         2'b10:   boothSum = boothA - mcand;
         default: boothSum = boothA;
      endcase
   end

   // Divisor magnitude carries an extra bit so -2^(W-1) stays exact.
   assign aMag    = op_a[WIDTH-1] ? -op_a : op_a;
   assign bMag    = op_b[WIDTH-1] ? -{1'b1, op_b} : {1'b0, op_b};
   assign divLoad = (state == IDLE) && !start_mult && start_div && (op_b != '0);
   assign divStep = (state == DIV);

   div_core #(.WIDTH(WIDTH)) uDivCore (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (divLoad),
      .step      (divStep),
      .dividend  (aMag),
      .divisor   (bMag),
      .quotient  (divQuo),
      .remainder (divRem)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         cnt      <= '0;
         boothA   <= '0;
         boothQ   <= '0;
         mcand    <= '0;
         qm1      <= 1'b0;
         negQ     <= 1'b0;
         negR     <= 1'b0;
         dzFlag   <= 1'b0;
         resHi    <= '0;
         resLo    <= '0;
         hi       <= '0;
         lo       <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         done     <= 1'b0;
         div_zero <= 1'b0;
         busy     <= (state == MULT) || (state == DIV) || (state == DIV_FIX);
         case (state)
            IDLE: begin
               if (start_mult) begin
                  mcand  <= {op_a[WIDTH-1], op_a};
                  boothA <= '0;
                  boothQ <= op_b;
                  qm1    <= 1'b0;
                  cnt    <= CW'(WIDTH - 1);
                  dzFlag <= 1'b0;
                  state  <= MULT;
               end else if (start_div) begin
                  negQ   <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                  negR   <= op_a[WIDTH-1];
                  cnt    <= CW'(WIDTH - 1);
                  dzFlag <= (op_b == '0);
                  state  <= (op_b == '0) ? FINISH : DIV;
               end
            end
            MULT: begin
               boothA <= {boothSum[WIDTH], boothSum[WIDTH:1]};
               boothQ <= {boothSum[0], boothQ[WIDTH-1:1]};
               qm1    <= boothQ[0];
               cnt    <= cnt - 1'b1;
               if (cnt == '0) begin
                  // Capture the product as it leaves the final shift.
                  resHi <= boothSum[WIDTH:1];
                  resLo <= {boothSum[0], boothQ[WIDTH-1:1]};
                  state <= FINISH;
               end
            end
            DIV: begin
               cnt <= cnt - 1'b1;
               if (cnt == '0) state <= DIV_FIX;
            end
            DIV_FIX: begin
               resLo <= negQ ? -divQuo : divQuo;
               resHi <= negR ? -divRem : divRem;
               state <= FINISH;
            end
            FINISH: begin
               done     <= 1'b1;
               div_zero <= dzFlag;
               if (!dzFlag) begin
                  hi <= resHi;
                  lo <= resLo;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit with hand-computed HI/LO, latency and flag checks.
module tb_mult_div_unit;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start_mult = 1'b0;
   logic        start_div = 1'b0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic [31:0] hi, lo;
   logic        busy, done, div_zero;

   int nVec = 0;
   int nMis = 0;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start_mult (start_mult),
      .start_div  (start_div),
      .op_a       (op_a),
      .op_b       (op_b),
      .hi         (hi),
      .lo         (lo),
      .busy       (busy),
      .done       (done),
      .div_zero   (div_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nVec++;
      if (got !== exp) begin
         nMis++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Start an op at an edge (cycle 0), then count cycles to done (bounded).
   task automatic runOp(input bit mul, input bit dv, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb, output int cyc, output int busyCnt, output bit dzSeen);
      bit gotDone;
      @(negedge clk);
      start_mult = mul;
      start_div  = dv;
      op_a       = a;
      op_b       = b;
      @(posedge clk);
      #1;
      start_mult = 1'b0;
      start_div  = 1'b0;
      cyc = 0; busyCnt = 0; dzSeen = 1'b0; gotDone = 1'b0;
      while (!gotDone && cyc < 60) begin
         @(posedge clk);
         #1;
         cyc++;
         if (busy) busyCnt++;
         if (done) begin
            gotDone = 1'b1;
            dzSeen  = div_zero;
         end
         if (disturb && cyc == 5) begin
            start_div = 1'b1;
            op_a      = 32'h0000_0009;
            op_b      = 32'h0000_0003;
         end
         if (disturb && cyc == 6) start_div = 1'b0;
      end
      if (!gotDone) chk("done_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      int  cyc, bc;
      bit  dz;

      #12;
      chk("rst_hilo", {hi, lo}, 64'd0);
      chk("rst_flags", {busy, done, div_zero}, 3'b000);
      @(negedge clk);
      reset_n = 1'b1;

      runOp(1, 0, 32'd7, 32'hFFFF_FFFD, 0, cyc, bc, dz);
      chk("mul7x-3", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
      chk("mul_lat", cyc, 33);
      chk("mul_busy", bc, 32);

      runOp(1, 0, 32'h8000_0000, 32'h8000_0000, 0, cyc, bc, dz);
      chk("mul_minmin", {hi, lo}, 64'h4000_0000_0000_0000);

      runOp(1, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, cyc, bc, dz);
      chk("mul_maxmax", {hi, lo}, 64'h3FFF_FFFF_0000_0001);

      runOp(0, 1, 32'hFFFF_FFF9, 32'd2, 0, cyc, bc, dz);
      chk("div-7/2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      chk("div_lat", cyc, 34);
      chk("div_busy", bc, 33);
      chk("div_nodz", dz, 0);

      runOp(0, 1, 32'd7, 32'hFFFF_FFFE, 0, cyc, bc, dz);
      chk("div7/-2", {hi, lo}, 64'h0000_0001_FFFF_FFFD);

      runOp(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, cyc, bc, dz);
      chk("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
      chk("div_ovf_dz", dz, 0);

      runOp(0, 1, 32'h0000_0451, 32'h0000_0020, 0, cyc, bc, dz);
      chk("div_prior", {hi, lo}, 64'h0000_0011_0000_0022);

      runOp(0, 1, 32'd5, 32'd0, 0, cyc, bc, dz);
      chk("dz_lat", cyc, 1);
      chk("dz_flag", dz, 1);
      chk("dz_busy", bc, 0);
      chk("dz_hold", {hi, lo}, 64'h0000_0011_0000_0022);

      runOp(1, 0, 32'd123, 32'hFFFF_FE38, 1, cyc, bc, dz);
      chk("mul_disturb", {hi, lo}, 64'hFFFF_FFFF_FFFF_24E8);
      chk("mul_dist_lat", cyc, 33);

      runOp(1, 1, 32'd6, 32'd7, 0, cyc, bc, dz);
      chk("both_start", {hi, lo}, 64'd42);
      chk("both_lat", cyc, 33);

      @(negedge clk);
      start_div = 1'b1; op_a = 32'd100; op_b = 32'd7;
      @(posedge clk);
      #1;
      start_div = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("busy_mid_div", busy, 1);
      reset_n = 1'b0;
      #1;
      chk("rst_mid_hilo", {hi, lo}, 64'd0);
      chk("rst_mid_busy", busy, 0);
      @(negedge clk);
      reset_n = 1'b1;

      runOp(1, 0, 32'd3, 32'd4, 0, cyc, bc, dz);
      chk("mul3x4", {hi, lo}, 64'd12);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end
endmodule
